// File: rtl/writeback_stage.sv
// MEM/WB stage: registers the retiring instruction, aligns/extends loads, drives the RF write port and decode bypass.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              hold,
  input  logic              flush,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [REG_AW-1:0] dest,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic [1:0]        load_size,
  input  logic              load_signed,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_a,
  output logic              fwd_b,
  output logic [DATA_W-1:0] retire_cnt
);

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  logic              vld_p1;
  logic              we_p1;
  logic [REG_AW-1:0] wa_p1;
  logic              m2r_p1;
  logic [1:0]        size_p1;
  logic              sgn_p1;
  logic [1:0]        offset_p1;
  logic [DATA_W-1:0] mem_data_p1;
  logic [DATA_W-1:0] alu_out_p1;

  logic [DATA_W-1:0] load_data;
  logic              wr_live;

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sg);
    logic signed [15:0] hs;
    logic signed [31:0] ws;
    hs = h;
    ws = hs;
    return sg ? ws : {16'h0000, h};
  endfunction

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sg);
    logic signed [7:0]  bs;
    logic signed [31:0] ws;
    bs = b;
    ws = bs;
    return sg ? ws : {24'h000000, b};
  endfunction

  // Big-endian lanes: offset 0 is the most significant byte/half.
  function automatic logic [31:0] align_load(input logic [31:0] word,
                                             input logic [1:0]  size,
                                             input logic [1:0]  offset,
                                             input logic        sg);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_h = offset[1] ? word[15:0] : word[31:16];
    case (offset)
      2'd0:    lane_b = word[31:24];
      2'd1:    lane_b = word[23:16];
      2'd2:    lane_b = word[15:8];
      default: lane_b = word[7:0];
    endcase
    case (size)
      SZ_HALF: return ext_half(lane_h, sg);
      SZ_BYTE: return ext_byte(lane_b, sg);
      SZ_WORD: return word;
      default: return word;
    endcase
  endfunction

  assign in_ready = !hold;

  // Stage boundary MEM -> WB: flush kills the incoming entry, hold freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1      <= 1'b0;
      we_p1       <= 1'b0;
      wa_p1       <= '0;
      m2r_p1      <= 1'b0;
      size_p1     <= SZ_WORD;
      sgn_p1      <= 1'b0;
      offset_p1   <= 2'b00;
      mem_data_p1 <= '0;
      alu_out_p1  <= '0;
    end else if (in_ready) begin
      vld_p1      <= in_valid & ~flush;
      we_p1       <= reg_write;
      wa_p1       <= dest;
      m2r_p1      <= mem_to_reg;
      size_p1     <= load_size;
      sgn_p1      <= load_signed;
      offset_p1   <= alu_out[1:0];
      mem_data_p1 <= mem_data;
      alu_out_p1  <= alu_out;
    end
  end

  // WB outputs: a held entry writes exactly once, in its first non-held cycle.
  assign load_data = align_load(mem_data_p1, size_p1, offset_p1, sgn_p1);
  assign wr_live   = vld_p1 & we_p1 & (wa_p1 != '0) & ~hold;

  assign rf_we    = wr_live;
  assign rf_waddr = wa_p1;
  assign rf_wdata = m2r_p1 ? load_data : alu_out_p1;
  assign fwd_a    = wr_live & (id_rs == wa_p1);
  assign fwd_b    = wr_live & (id_rt == wa_p1);

`ifdef WB_RETIRE_CNT_EN
  logic [DATA_W-1:0] retire_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      retire_cnt_q <= '0;
    else if (vld_p1 && !hold)
      retire_cnt_q <= retire_cnt_q + 1'b1;
  end

  assign retire_cnt = retire_cnt_q;
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, reset/hold/flush/counter sequences, randomized run vs. a model.
module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        hold;
  logic        flush;
  logic [31:0] mem_data;
  logic [31:0] alu_out;
  logic [4:0]  dest;
  logic        reg_write;
  logic        mem_to_reg;
  logic [1:0]  load_size;
  logic        load_signed;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_a;
  logic        fwd_b;
  logic [31:0] retire_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  writeback_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .hold(hold), .flush(flush), .mem_data(mem_data), .alu_out(alu_out),
    .dest(dest), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .load_size(load_size), .load_signed(load_signed), .id_rs(id_rs), .id_rt(id_rt),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] md;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rw;
    logic        m2r;
    logic [1:0]  size;
    logic        sgn;
    logic        exp_we;
    logic [31:0] exp_wd;
    logic        exp_fa;
    logic        exp_fb;
  } vec_t;

  typedef struct {
    logic        v;
    logic        we;
    logic [4:0]  wa;
    logic        m2r;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] md;
    logic [31:0] alu;
  } wb_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; hold = 0; flush = 0; mem_data = 0; alu_out = 0; dest = 0;
    reg_write = 0; mem_to_reg = 0; load_size = 0; load_signed = 0; id_rs = 0; id_rt = 0;
  endtask

  task automatic present_write(input logic [4:0] d, input logic [31:0] a);
    in_valid = 1; reg_write = 1; mem_to_reg = 0; dest = d; alu_out = a;
    load_size = 0; load_signed = 0;
  endtask

  task automatic reset_pulse();
    #2 rst = 0;
    #2 rst = 1;
  endtask

  // Load result computed from shifts and masks on the whole word.
  function automatic logic [31:0] ref_data(input wb_t e);
    int unsigned w;
    int unsigned sh;
    int unsigned off;
    off = int'(e.alu & 32'h3);
    if (!e.m2r) return e.alu;
    w = e.md;
    if (e.size == 2'd1) begin
      sh = (off >= 2) ? 0 : 16;
      w = (e.md >> sh) & 32'hFFFF;
      if (e.sgn && w >= 32'h8000) w = w + 32'hFFFF_0000;
    end else if (e.size == 2'd2) begin
      sh = 8 * (3 - off);
      w = (e.md >> sh) & 32'hFF;
      if (e.sgn && w >= 32'h80) w = w + 32'hFFFF_FF00;
    end
    return w;
  endfunction

  initial begin
    wb_t         m;
    int unsigned cnt_model;
    logic        exp_we;

    vecs[0]  = '{32'h0,         32'h1234_5678, 5'd5,  5'd5, 5'd6, 1, 0, 2'd0, 0, 1, 32'h1234_5678, 1, 0};
    vecs[1]  = '{32'h11A2_3344, 32'h0000_1001, 5'd3,  5'd0, 5'd3, 1, 1, 2'd2, 1, 1, 32'hFFFF_FFA2, 0, 1};
    vecs[2]  = '{32'h11A2_3344, 32'h0000_1001, 5'd3,  5'd0, 5'd3, 1, 1, 2'd2, 0, 1, 32'h0000_00A2, 0, 1};
    vecs[3]  = '{32'h8001_7FFE, 32'h0000_2000, 5'd8,  5'd8, 5'd8, 1, 1, 2'd1, 1, 1, 32'hFFFF_8001, 1, 1};
    vecs[4]  = '{32'h8001_7FFE, 32'h0000_2002, 5'd8,  5'd8, 5'd8, 1, 1, 2'd1, 1, 1, 32'h0000_7FFE, 1, 1};
    vecs[5]  = '{32'h8001_7FFE, 32'h0000_2000, 5'd8,  5'd8, 5'd8, 1, 1, 2'd1, 0, 1, 32'h0000_8001, 1, 1};
    vecs[6]  = '{32'h8001_7FFE, 32'h0000_2003, 5'd8,  5'd8, 5'd8, 1, 1, 2'd1, 1, 1, 32'h0000_7FFE, 1, 1};
    vecs[7]  = '{32'h8001_7FFE, 32'h0000_2001, 5'd8,  5'd8, 5'd8, 1, 1, 2'd1, 1, 1, 32'hFFFF_8001, 1, 1};
    vecs[8]  = '{32'h80FF_7F01, 32'h0000_0000, 5'd12, 5'd1, 5'd2, 1, 1, 2'd2, 1, 1, 32'hFFFF_FF80, 0, 0};
    vecs[9]  = '{32'h80FF_7F01, 32'h0000_0003, 5'd12, 5'd1, 5'd2, 1, 1, 2'd2, 1, 1, 32'h0000_0001, 0, 0};
    vecs[10] = '{32'h80FF_7F01, 32'h0000_0002, 5'd12, 5'd1, 5'd2, 1, 1, 2'd2, 1, 1, 32'h0000_007F, 0, 0};
    vecs[11] = '{32'h80FF_7F01, 32'h0000_0001, 5'd12, 5'd1, 5'd2, 1, 1, 2'd2, 1, 1, 32'hFFFF_FFFF, 0, 0};
    vecs[12] = '{32'hCAFE_BABE, 32'h0000_0003, 5'd9,  5'd1, 5'd2, 1, 1, 2'd0, 1, 1, 32'hCAFE_BABE, 0, 0};
    vecs[13] = '{32'hCAFE_BABE, 32'h0000_0001, 5'd9,  5'd1, 5'd2, 1, 1, 2'd3, 1, 1, 32'hCAFE_BABE, 0, 0};
    vecs[14] = '{32'h0,         32'hDEAD_BEEF, 5'd0,  5'd0, 5'd0, 1, 0, 2'd0, 0, 0, 32'hDEAD_BEEF, 0, 0};
    vecs[15] = '{32'h0,         32'h0000_0077, 5'd7,  5'd7, 5'd7, 1, 0, 2'd0, 0, 1, 32'h0000_0077, 1, 1};
    vecs[16] = '{32'h0,         32'h0000_0088, 5'd7,  5'd7, 5'd7, 0, 0, 2'd0, 0, 0, 32'h0000_0088, 0, 0};

    // Reset state
    idle_inputs();
    rst = 0;
    #12;
    chk("reset_rf_we", rf_we, 0);
    chk("reset_rf_waddr", rf_waddr, 0);
    chk("reset_rf_wdata", rf_wdata, 0);
    chk("reset_fwd_a", fwd_a, 0);
    chk("reset_fwd_b", fwd_b, 0);
    chk("reset_retire_cnt", retire_cnt, 0);
    chk("reset_in_ready", in_ready, 1);
    hold = 1;
    #1 chk("reset_in_ready_hold", in_ready, 0);
    hold = 0;
    tick();
    rst = 1;

    // ALU write, then asynchronous reset mid-cycle
    present_write(5'd5, 32'h1234_5678);
    tick();
    chk("alu_we", rf_we, 1);
    chk("alu_waddr", rf_waddr, 5);
    chk("alu_wdata", rf_wdata, 32'h1234_5678);
    in_valid = 0;
    #3 rst = 0;
    #1;
    chk("async_rst_we", rf_we, 0);
    chk("async_rst_wdata", rf_wdata, 0);
    chk("async_rst_waddr", rf_waddr, 0);
    #1 rst = 1;

    // Vector table
    for (int i = 0; i < 17; i++) begin
      in_valid = 1; hold = 0; flush = 0;
      mem_data = vecs[i].md; alu_out = vecs[i].alu; dest = vecs[i].dest;
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; reg_write = vecs[i].rw;
      mem_to_reg = vecs[i].m2r; load_size = vecs[i].size; load_signed = vecs[i].sgn;
      tick();
      chk($sformatf("vec%0d_we", i), rf_we, vecs[i].exp_we);
      chk($sformatf("vec%0d_waddr", i), rf_waddr, vecs[i].dest);
      chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].exp_wd);
      chk($sformatf("vec%0d_fwd_a", i), fwd_a, vecs[i].exp_fa);
      chk($sformatf("vec%0d_fwd_b", i), fwd_b, vecs[i].exp_fb);
    end

    // Hold with a valid write in WB, then release
    present_write(5'd9, 32'hAAAA_5555);
    id_rs = 9; id_rt = 9;
    @(posedge clk);
    #1 hold = 1;
    present_write(5'd10, 32'h0BAD_0BAD);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d_we", c), rf_we, 0);
      chk($sformatf("hold%0d_in_ready", c), in_ready, 0);
      chk($sformatf("hold%0d_waddr", c), rf_waddr, 9);
      chk($sformatf("hold%0d_wdata", c), rf_wdata, 32'hAAAA_5555);
      chk($sformatf("hold%0d_fwd_a", c), fwd_a, 0);
      tick();
    end
    in_valid = 0;
    hold = 0;
    #1;
    chk("release_we", rf_we, 1);
    chk("release_waddr", rf_waddr, 9);
    chk("release_fwd_b", fwd_b, 1);
    tick();
    chk("release_we_once", rf_we, 0);

    // Flush blocks capture
    present_write(5'd4, 32'h4444_4444);
    flush = 1;
    tick();
    chk("flush_we", rf_we, 0);
    flush = 0;
    in_valid = 0;
    tick();

`ifdef WB_RETIRE_CNT_EN
    reset_pulse();
    chk("cnt_after_reset", retire_cnt, 0);
    for (int k = 0; k < 4; k++) begin
      present_write(5'(k + 1), 32'(k));
      tick();
    end
    hold = 1;
    tick();
    tick();
    chk("cnt_during_hold", retire_cnt, 3);
    hold = 0;
    flush = 1;
    tick();
    flush = 0;
    in_valid = 0;
    tick();
    tick();
    chk("cnt_four", retire_cnt, 4);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt_q;
    #1 chk("cnt_forced", retire_cnt, 32'hFFFF_FFFF);
    present_write(5'd2, 32'h1);
    tick();
    in_valid = 0;
    tick();
    chk("cnt_wrap", retire_cnt, 0);
`endif

    // Randomized run against the model, from a fresh reset
    idle_inputs();
    reset_pulse();
    m = '{0, 0, 5'd0, 0, 2'd0, 0, 32'h0, 32'h0};
    cnt_model = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      hold        = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 6) == 0);
      dest        = 5'($urandom_range(0, 7));
      id_rs       = 5'($urandom_range(0, 7));
      id_rt       = 5'($urandom_range(0, 7));
      mem_data    = $urandom;
      alu_out     = $urandom;
      reg_write   = ($urandom_range(0, 4) != 0);
      mem_to_reg  = $urandom_range(0, 1);
      load_size   = 2'($urandom_range(0, 3));
      load_signed = $urandom_range(0, 1);
      #1;
      exp_we = m.v && m.we && (m.wa != 0) && !hold;
      chk("rnd_in_ready", in_ready, !hold);
      chk("rnd_we", rf_we, exp_we);
      chk("rnd_waddr", rf_waddr, m.wa);
      chk("rnd_wdata", rf_wdata, ref_data(m));
      chk("rnd_fwd_a", fwd_a, exp_we && (id_rs == m.wa));
      chk("rnd_fwd_b", fwd_b, exp_we && (id_rt == m.wa));
`ifdef WB_RETIRE_CNT_EN
      chk("rnd_retire_cnt", retire_cnt, cnt_model);
`else
      chk("rnd_retire_cnt", retire_cnt, 0);
`endif
      @(posedge clk);
      if (!hold) begin
        if (m.v) cnt_model++;
        m = '{in_valid && !flush, reg_write, dest, mem_to_reg, load_size, load_signed, mem_data, alu_out};
      end
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
